// File: rtl/cam_arbiter.sv
// Round-robin arbiter that serialises read/write/search requests from NUM_REQ clients
// onto one shared 32x32 CAM, with a single op in flight at a time.
module cam_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CAM_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [2*NUM_REQ-1:0]  req_op_i,
    input  logic [5*NUM_REQ-1:0]  req_index_i,
    input  logic [32*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic [NUM_REQ-1:0]    resp_valid_o,
    output logic                  resp_hit_o,
    output logic [4:0]            resp_index_o,
    output logic [31:0]           resp_data_o,
    output logic                  resp_err_o,
    output logic                  busy_o,
    output logic                  cam_read_enable_o,
    output logic [4:0]            cam_read_index_o,
    output logic                  cam_write_enable_o,
    output logic [4:0]            cam_write_index_o,
    output logic [31:0]           cam_write_data_o,
    output logic                  cam_search_enable_o,
    output logic [31:0]           cam_search_data_o,
    input  logic                  cam_read_valid_i,
    input  logic [31:0]           cam_read_value_i,
    input  logic                  cam_search_valid_i,
    input  logic [4:0]            cam_search_index_i
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int LW = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_SEARCH = 2'b10, OP_ILLEGAL = 2'b11} op_t;

    state_t          r_state;
    state_t          w_next_state;
    op_t             r_op;
    logic [4:0]      r_index;
    logic [31:0]     r_data;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_rr;
    logic [LW-1:0]   r_lat_cnt;
    logic            r_resp_hit;
    logic [4:0]      r_resp_index;
    logic [31:0]     r_resp_data;
    logic            r_resp_err;
    logic            w_grant_valid;
    logic [OW-1:0]   w_grant_idx;
    logic            w_accept;
    logic            w_sample;

    function automatic logic [OW-1:0] f_wrap(input int v);
        return (v >= NUM_REQ) ? OW'(v - NUM_REQ) : OW'(v);
    endfunction

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        // Scan from lowest priority upward; the last valid hit is the round-robin winner.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[f_wrap(int'(r_rr) + i)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = f_wrap(int'(r_rr) + i);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_grant_valid;
    assign w_sample = (r_state == S_WAIT) && (r_lat_cnt == '0);

    always_comb begin
        w_next_state        = r_state;
        req_ready_o         = '0;
        resp_valid_o        = '0;
        resp_hit_o          = 1'b0;
        resp_index_o        = '0;
        resp_data_o         = '0;
        resp_err_o          = 1'b0;
        busy_o              = (r_state != S_IDLE);
        cam_read_enable_o   = 1'b0;
        cam_read_index_o    = '0;
        cam_write_enable_o  = 1'b0;
        cam_write_index_o   = '0;
        cam_write_data_o    = '0;
        cam_search_enable_o = 1'b0;
        cam_search_data_o   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    req_ready_o[w_grant_idx] = 1'b1;
                    w_next_state             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
                case (r_op)
                    OP_READ: begin
                        cam_read_enable_o = 1'b1;
                        cam_read_index_o  = r_index;
                    end
                    OP_WRITE: begin
                        cam_write_enable_o = 1'b1;
                        cam_write_index_o  = r_index;
                        cam_write_data_o   = r_data;
                    end
                    OP_SEARCH: begin
                        cam_search_enable_o = 1'b1;
                        cam_search_data_o   = r_data;
                    end
                    default: ;
                endcase
            end
            S_WAIT: begin
                if (r_lat_cnt == '0) w_next_state = S_RESP;
            end
            S_RESP: begin
                w_next_state          = S_IDLE;
                resp_valid_o[r_owner] = 1'b1;
                resp_hit_o            = r_resp_hit;
                resp_index_o          = r_resp_index;
                resp_data_o           = r_resp_data;
                resp_err_o            = r_resp_err;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_op         <= OP_READ;
            r_index      <= '0;
            r_data       <= '0;
            r_owner      <= '0;
            r_rr         <= '0;
            r_lat_cnt    <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_index <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= op_t'(req_op_i[2*int'(w_grant_idx) +: 2]);
                r_index <= req_index_i[5*int'(w_grant_idx) +: 5];
                r_data  <= req_data_i[32*int'(w_grant_idx) +: 32];
                r_owner <= w_grant_idx;
                r_rr    <= (int'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + 1'b1;
            end
            if (r_state == S_ISSUE)
                r_lat_cnt <= LW'(CAM_LAT - 1);
            else if (r_state == S_WAIT && r_lat_cnt != '0)
                r_lat_cnt <= r_lat_cnt - 1'b1;
            if (w_sample) begin
                r_resp_hit   <= 1'b0;
                r_resp_index <= '0;
                r_resp_data  <= '0;
                r_resp_err   <= 1'b0;
                case (r_op)
                    OP_READ: begin
                        r_resp_hit  <= cam_read_valid_i;
                        r_resp_data <= cam_read_valid_i ? cam_read_value_i : '0;
                    end
                    OP_SEARCH: begin
                        r_resp_hit   <= cam_search_valid_i;
                        r_resp_index <= cam_search_valid_i ? cam_search_index_i : '0;
                    end
                    OP_ILLEGAL: r_resp_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cam_arbiter.sv
// Directed bench for cam_arbiter: behavioural CAM, transaction-level reference model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_cam_arbiter;
    localparam int NUM_REQ = 4;
    localparam int CAM_LAT = 1;
    localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_SR = 2'b10, OP_IL = 2'b11;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [2*NUM_REQ-1:0]  req_op = '0;
    logic [5*NUM_REQ-1:0]  req_index = '0;
    logic [32*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]    req_ready_o, resp_valid_o;
    logic                  resp_hit_o, resp_err_o, busy_o;
    logic [4:0]            resp_index_o, cam_read_index_o, cam_write_index_o;
    logic [31:0]           resp_data_o, cam_write_data_o, cam_search_data_o;
    logic                  cam_read_enable_o, cam_write_enable_o, cam_search_enable_o;
    logic                  cam_read_valid = 1'b0, cam_search_valid = 1'b0;
    logic [31:0]           cam_read_value = '0;
    logic [4:0]            cam_search_index = '0;

    cam_arbiter #(.NUM_REQ(NUM_REQ), .CAM_LAT(CAM_LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_op_i(req_op), .req_index_i(req_index), .req_data_i(req_data),
        .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o),
        .resp_index_o(resp_index_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .busy_o(busy_o),
        .cam_read_enable_o(cam_read_enable_o), .cam_read_index_o(cam_read_index_o),
        .cam_write_enable_o(cam_write_enable_o), .cam_write_index_o(cam_write_index_o),
        .cam_write_data_o(cam_write_data_o),
        .cam_search_enable_o(cam_search_enable_o), .cam_search_data_o(cam_search_data_o),
        .cam_read_valid_i(cam_read_valid), .cam_read_value_i(cam_read_value),
        .cam_search_valid_i(cam_search_valid), .cam_search_index_i(cam_search_index)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural CAM: outputs are valid only in the cycle after the enable; garbage otherwise.
    logic [31:0] cam_mem [32];
    logic [31:0] cam_vld = '0;

    function automatic logic [5:0] cam_find(input logic [31:0] key);
        logic [5:0] res;
        res = {1'b0, 5'd31};
        for (int j = 31; j >= 0; j--)
            if (cam_vld[j] && cam_mem[j] == key) res = {1'b1, 5'(j)};
        return res;
    endfunction

    always @(posedge clk_i) begin
        logic [5:0] f;
        f = cam_find(cam_search_data_o);
        cam_read_valid   <= cam_read_enable_o && cam_vld[cam_read_index_o];
        cam_read_value   <= (cam_read_enable_o && cam_vld[cam_read_index_o]) ? cam_mem[cam_read_index_o] : 32'hBAD0_BAD0;
        cam_search_valid <= cam_search_enable_o && f[5];
        cam_search_index <= f[4:0];
        if (cam_write_enable_o) begin
            cam_mem[cam_write_index_o] <= cam_write_data_o;
            cam_vld[cam_write_index_o] <= 1'b1;
        end
    end

    longint cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model: timeline of accept/issue/response cycles derived from the latency rules.
    int          m_rr = 0;
    longint      m_free_at = 0, m_iss_cyc = -1, m_rsp_cyc = -1;
    logic [1:0]  m_op = '0;
    logic [4:0]  m_idx = '0, m_ridx = '0;
    logic [31:0] m_dat = '0, m_rdat = '0;
    logic        m_hit = 1'b0, m_err = 1'b0;
    int          m_owner = 0;
    int          grant_log[$];

    always @(negedge clk_i) begin
        logic [NUM_REQ-1:0] exp_ready, exp_rv;
        logic [5:0] f;
        int g;
        if (!rst_i) begin
            check("reset_outputs_zero", 32'(|{req_ready_o, resp_valid_o, resp_hit_o, resp_index_o, resp_data_o,
                  resp_err_o, busy_o, cam_read_enable_o, cam_read_index_o, cam_write_enable_o, cam_write_index_o,
                  cam_write_data_o, cam_search_enable_o, cam_search_data_o}), 0);
            m_rr = 0; m_free_at = 0; m_iss_cyc = -1; m_rsp_cyc = -1;
        end else begin
            g = -1;
            if (cyc >= m_free_at)
                for (int k = 0; k < NUM_REQ; k++)
                    if (g < 0 && req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", 32'(req_ready_o), 32'(exp_ready));
            check("busy", 32'(busy_o), 32'(cyc < m_free_at));
            if (cyc == m_iss_cyc) begin
                check("rd_en", 32'(cam_read_enable_o), 32'(m_op == OP_RD));
                check("wr_en", 32'(cam_write_enable_o), 32'(m_op == OP_WR));
                check("sr_en", 32'(cam_search_enable_o), 32'(m_op == OP_SR));
                if (m_op == OP_RD) check("rd_index", 32'(cam_read_index_o), 32'(m_idx));
                if (m_op == OP_WR) begin
                    check("wr_index", 32'(cam_write_index_o), 32'(m_idx));
                    check("wr_data", cam_write_data_o, m_dat);
                end
                if (m_op == OP_SR) check("sr_data", cam_search_data_o, m_dat);
            end else begin
                check("no_cam_enable", 32'({cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}), 0);
            end
            if (cyc == m_rsp_cyc) begin
                exp_rv = NUM_REQ'(1 << m_owner);
                check("resp_valid", 32'(resp_valid_o), 32'(exp_rv));
                check("resp_hit", 32'(resp_hit_o), 32'(m_hit));
                check("resp_index", 32'(resp_index_o), 32'(m_ridx));
                check("resp_data", resp_data_o, m_rdat);
                check("resp_err", 32'(resp_err_o), 32'(m_err));
            end else begin
                check("resp_idle_zero", 32'(|{resp_valid_o, resp_hit_o, resp_index_o, resp_data_o, resp_err_o}), 0);
            end
            if (g >= 0) begin
                m_op = req_op[2*g +: 2];
                m_idx = req_index[5*g +: 5];
                m_dat = req_data[32*g +: 32];
                m_owner = g;
                m_hit = 1'b0; m_ridx = '0; m_rdat = '0; m_err = 1'b0;
                case (m_op)
                    OP_RD: if (cam_vld[m_idx]) begin m_hit = 1'b1; m_rdat = cam_mem[m_idx]; end
                    OP_SR: begin
                        f = cam_find(m_dat);
                        if (f[5]) begin m_hit = 1'b1; m_ridx = f[4:0]; end
                    end
                    OP_IL: m_err = 1'b1;
                    default: ;
                endcase
                m_iss_cyc = cyc + 1;
                m_rsp_cyc = cyc + CAM_LAT + 2;
                m_free_at = cyc + CAM_LAT + 3;
                m_rr = (g + 1) % NUM_REQ;
                grant_log.push_back(g);
            end
        end
    end

    logic [NUM_REQ-1:0] cap_rv;
    logic               cap_hit, cap_err, cap_got, cap_saw_en;
    logic [4:0]         cap_idx;
    logic [31:0]        cap_data;
    int                 cap_lat;

    task automatic do_op(input int r, input logic [1:0] op, input logic [4:0] idx, input logic [31:0] data);
        int n;
        longint t_acc;
        @(posedge clk_i); #1;
        req_valid[r] = 1'b1;
        req_op[2*r +: 2] = op;
        req_index[5*r +: 5] = idx;
        req_data[32*r +: 32] = data;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o[r] && n < 50) begin @(negedge clk_i); n++; end
        check("accept_in_time", 32'(req_ready_o[r]), 1);
        t_acc = cyc;
        @(posedge clk_i); #1;
        req_valid[r] = 1'b0;
        cap_got = 1'b0; cap_saw_en = 1'b0; cap_rv = '0; n = 0;
        while (!cap_got && n < 20) begin
            @(negedge clk_i); n++;
            if (cam_read_enable_o || cam_write_enable_o || cam_search_enable_o) cap_saw_en = 1'b1;
            if (resp_valid_o != '0) begin
                cap_got = 1'b1; cap_rv = resp_valid_o; cap_hit = resp_hit_o; cap_idx = resp_index_o;
                cap_data = resp_data_o; cap_err = resp_err_o; cap_lat = int'(cyc - t_acc);
            end
        end
        check("resp_in_time", 32'(cap_got), 1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk_i); #2 rst_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #2 rst_i = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n;
        logic saw;
        // 1. reset then idle
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("idle_busy", 32'(busy_o), 0);
        check("idle_ready", 32'(req_ready_o), 0);

        // 2. write then read, plus a read miss; response 3 cycles after accept for CAM_LAT=1
        do_op(0, OP_WR, 5'd5, 32'hDEAD_BEEF);
        check("wr_resp_valid", 32'(cap_rv), 32'b0001);
        check("wr_resp_hit", 32'(cap_hit), 0);
        check("wr_resp_data", cap_data, 0);
        check("wr_latency", 32'(cap_lat), 3);
        do_op(0, OP_RD, 5'd5, 32'h0);
        check("rd_resp_hit", 32'(cap_hit), 1);
        check("rd_resp_data", cap_data, 32'hDEAD_BEEF);
        check("rd_latency", 32'(cap_lat), 3);
        do_op(0, OP_RD, 5'd7, 32'h0);
        check("rd_miss_hit", 32'(cap_hit), 0);
        check("rd_miss_data", cap_data, 0);

        // 3. search hit and miss from requester 2
        do_op(2, OP_SR, 5'd0, 32'hDEAD_BEEF);
        check("sr_hit_valid", 32'(cap_rv), 32'b0100);
        check("sr_hit", 32'(cap_hit), 1);
        check("sr_hit_index", 32'(cap_idx), 5);
        do_op(2, OP_SR, 5'd0, 32'h1234_5678);
        check("sr_miss_hit", 32'(cap_hit), 0);
        check("sr_miss_index", 32'(cap_idx), 0);

        // 5. illegal op
        do_op(1, OP_IL, 5'd3, 32'h0);
        check("il_no_enable", 32'(cap_saw_en), 0);
        check("il_resp_valid", 32'(cap_rv), 32'b0010);
        check("il_err", 32'(cap_err), 1);
        check("il_hit", 32'(cap_hit), 0);

        // 4. round-robin with all requesters continuously valid
        do_reset(2);
        grant_log.delete();
        @(posedge clk_i); #1;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_op[2*r +: 2] = OP_RD;
            req_index[5*r +: 5] = 5'(r);
        end
        req_valid = '1;
        n = 0;
        while (grant_log.size() < 5 && n < 100) begin @(posedge clk_i); n++; end
        #1 req_valid = '0;
        check("rr_grant_count", 32'(grant_log.size() >= 5), 1);
        if (grant_log.size() >= 5)
            for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
        repeat (10) @(posedge clk_i);

        // 6. reset while an op waits on the CAM
        #1;
        req_valid[1] = 1'b1;
        req_op[2*1 +: 2] = OP_SR;
        req_data[32*1 +: 32] = 32'hDEAD_BEEF;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o[1] && n < 50) begin @(negedge clk_i); n++; end
        check("abort_accept", 32'(req_ready_o[1]), 1);
        @(posedge clk_i); #1 req_valid[1] = 1'b0;
        @(posedge clk_i); #2 rst_i = 1'b0;
        #1;
        check("abort_busy_now", 32'(busy_o), 0);
        check("abort_enables_now", 32'({cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}), 0);
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1;
        saw = 1'b0;
        repeat (8) begin @(negedge clk_i); if (resp_valid_o != '0) saw = 1'b1; end
        check("abort_no_resp", 32'(saw), 0);
        @(posedge clk_i); #1;
        req_op[2*0 +: 2] = OP_RD; req_index[5*0 +: 5] = 5'd5;
        req_op[2*3 +: 2] = OP_RD; req_index[5*3 +: 5] = 5'd5;
        req_valid = 4'b1001;
        n = 0;
        @(negedge clk_i);
        while (req_ready_o == '0 && n < 50) begin @(negedge clk_i); n++; end
        check("post_reset_grant", 32'(req_ready_o), 32'b0001);
        @(posedge clk_i); #1 req_valid = '0;
        saw = 1'b0; n = 0;
        while (!saw && n < 20) begin
            @(negedge clk_i); n++;
            if (resp_valid_o != '0) begin
                saw = 1'b1;
                check("post_reset_resp_valid", 32'(resp_valid_o), 32'b0001);
                check("post_reset_resp_data", resp_data_o, 32'hDEAD_BEEF);
            end
        end
        check("post_reset_resp_in_time", 32'(saw), 1);
        repeat (5) @(posedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
